// File: rtl/tlc_multiway.sv
// tlc_multiway: round-robin traffic light controller for NUM_DIR approaches.
// Each direction runs GREEN -> YELLOW -> ALL-RED with fixed durations.
// Pedestrian requests are latched and served as WALK on that direction's next
// green. An emergency request preempts the rotation to a chosen direction.
module tlc_multiway #(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 16,
    parameter int YELLOW_CYC = 5,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 8,
    localparam int DIR_W     = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DIR-1:0]     ped_req,
    input  logic                   emerg_req,
    input  logic [DIR_W-1:0]       emerg_dir,
    output logic [3*NUM_DIR-1:0]   light,
    output logic [NUM_DIR-1:0]     walk,
    output logic [DIR_W-1:0]       cur_dir,
    output logic                   emerg_active
);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_EMERG  = 2'd3
    } state_t;

    // Timer load values: a state lasts exactly (load + 1) clocks.
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     tmr, tmr_n;
    logic [DIR_W-1:0]     cur_dir_n;
    logic [NUM_DIR-1:0]   walk_n;
    logic [NUM_DIR-1:0]   ped_pending, ped_pending_n;
    logic [NUM_DIR-1:0]   ped_clear;
    logic [NUM_DIR-1:0]   cur_mask;
    logic                 emerg_ok;
    logic                 emerg_hit;

    // An emergency request only counts when it names an existing direction.
    // When DIR_W exactly spans NUM_DIR every encodable value is valid.
    if ((1 << DIR_W) == NUM_DIR) begin : g_dir_full
        assign emerg_ok = emerg_req;
    end else begin : g_dir_partial
        assign emerg_ok = emerg_req && (emerg_dir < DIR_W'(NUM_DIR));
    end

    assign emerg_hit = emerg_ok && (emerg_dir == cur_dir);
    assign cur_mask  = NUM_DIR'(1) << cur_dir;

    // State, timer, phase and pedestrian registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_ALLRED;
            tmr         <= ALLRED_LD;
            cur_dir     <= '0;
            walk        <= '0;
            ped_pending <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the next-state logic.
            state       <= state_n;
            tmr         <= tmr_n;
            cur_dir     <= cur_dir_n;
            walk        <= walk_n;
            ped_pending <= ped_pending_n;
        end
    end

    // Next-state, timer reload, direction advance and WALK hand-off.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n   = state;
        tmr_n     = (tmr != '0) ? tmr - CNT_W'(1) : tmr;
        cur_dir_n = cur_dir;
        walk_n    = walk;
        ped_clear = '0;

        case (state)
            S_ALLRED: begin
                if (tmr == '0) begin
                    if (emerg_ok) begin
                        state_n   = S_EMERG;
                        tmr_n     = '0;
                        cur_dir_n = emerg_dir;
                        walk_n    = '0;
                    end else begin
                        state_n   = S_GREEN;
                        tmr_n     = GREEN_LD;
                        walk_n    = ped_pending & cur_mask;
                        ped_clear = cur_mask;
                    end
                end
            end
            S_GREEN: begin
                if (emerg_hit) begin
                    // Already green for the emergency direction: no gap.
                    state_n = S_EMERG;
                    tmr_n   = '0;
                    walk_n  = '0;
                end else if (emerg_ok || tmr == '0) begin
                    state_n = S_YELLOW;
                    tmr_n   = YELLOW_LD;
                    walk_n  = '0;
                end
            end
            S_YELLOW: begin
                if (tmr == '0) begin
                    state_n   = S_ALLRED;
                    tmr_n     = ALLRED_LD;
                    cur_dir_n = (cur_dir == LAST_DIR) ? '0 : cur_dir + DIR_W'(1);
                end
            end
            S_EMERG: begin
                // Timer frozen; leave through YELLOW on release or retarget.
                tmr_n = tmr;
                if (!emerg_hit) begin
                    state_n = S_YELLOW;
                    tmr_n   = YELLOW_LD;
                end
            end
            default: begin
                state_n = S_ALLRED;
                tmr_n   = ALLRED_LD;
            end
        endcase

        // A press in the same cycle as the clear stays pending.
        ped_pending_n = (ped_pending & ~ped_clear) | ped_req;
    end

    // Lamp decode from registered state and direction only.
    always_comb begin
        light = {NUM_DIR{3'b100}};
        for (int d = 0; d < NUM_DIR; d++) begin
            if (DIR_W'(d) == cur_dir) begin
                case (state)
                    S_GREEN, S_EMERG: light[3*d +: 3] = 3'b001;
                    S_YELLOW:         light[3*d +: 3] = 3'b010;
                    default:          light[3*d +: 3] = 3'b100;
                endcase
            end
        end
    end

    assign emerg_active = (state == S_EMERG);

endmodule
